// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: lock-state enum, error-counter width and
// the Gray-to-binary conversion used by the decoder and the counter's bench.
package gray_pkg;

   localparam int ERR_CNT_W  = 8;
   localparam int GRAY_MAX_W = 32;

   typedef enum logic [1:0] {
      ACQUIRE,
      TRACK,
      LOST
   } state_t;

   // Conversion runs at the maximum width; callers zero-extend narrower codes,
   // which leaves the upper binary bits at zero and the lower bits correct.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_step_decoder_if.sv
// Sample/result bundle between a Gray-count source and the step decoder.
interface gray_step_decoder_if #(
   parameter int WIDTH = 3
);

   logic                           in_valid;
   logic [WIDTH-1:0]               gray_in;
   logic                           out_valid;
   logic [WIDTH-1:0]               bin_out;
   logic                           dir_up;
   logic                           step_err;
   logic                           locked;
   logic [gray_pkg::ERR_CNT_W-1:0] err_count;

   modport master (
      output in_valid, gray_in,
      input  out_valid, bin_out, dir_up, step_err, locked, err_count
   );

   modport slave (
      input  in_valid, gray_in,
      output out_valid, bin_out, dir_up, step_err, locked, err_count
   );

endinterface

// File: rtl/gray_step_decoder.sv
// Two-stage Gray-count receiver: registers the sample, converts it to binary,
// classifies the step against the previous value and tracks lock state.
module gray_step_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int ERR_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   gray_step_decoder_if.slave  bus
);

   localparam int                CONSEC_W    = $clog2(ERR_LIMIT + 1);
   localparam logic [CONSEC_W-1:0] ERR_LIMIT_C = CONSEC_W'(ERR_LIMIT);

   logic                  r_s1_valid;
   logic [WIDTH-1:0]      r_s1_gray;
   state_t                r_state;
   logic [WIDTH-1:0]      r_prev;
   logic [WIDTH-1:0]      r_bin;
   logic                  r_dir_up;
   logic                  r_out_valid;
   logic                  r_step_err;
   logic                  r_locked;
   logic [ERR_CNT_W-1:0]  r_err_count;
   logic [CONSEC_W-1:0]   r_consec;
   logic                  r_lost_run;

   logic [GRAY_MAX_W-1:0] w_cur_full;
   logic [WIDTH-1:0]      w_cur;
   logic [WIDTH-1:0]      w_delta;
   logic                  w_hold;
   logic                  w_up;
   logic                  w_down;
   logic                  w_illegal;
   logic [CONSEC_W-1:0]   w_consec_inc;

   assign w_cur_full   = gray2bin(GRAY_MAX_W'(r_s1_gray));
   assign w_cur        = w_cur_full[WIDTH-1:0];
   assign w_delta      = w_cur - r_prev;  // wraps modulo 2^WIDTH
   assign w_hold       = (w_delta == '0);
   assign w_up         = (w_delta == WIDTH'(1));
   assign w_down       = (w_delta == '1);
   assign w_illegal    = !(w_hold || w_up || w_down);
   assign w_consec_inc = r_consec + 1'b1;

   // Stage-1 sample register for the Gray code.
   // NOTE: the data register carries no reset; r_s1_valid alone decides whether it is used.
   always_ff @(posedge clk) begin
      r_s1_gray <= bus.gray_in;
   end

   // Stage-1 valid, step classification, error counting and lock state machine.
   // NOTE: every state register uses <= so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_state     <= ACQUIRE;
         r_prev      <= '0;
         r_bin       <= '0;
         r_dir_up    <= 1'b1;
         r_out_valid <= 1'b0;
         r_step_err  <= 1'b0;
         r_locked    <= 1'b0;
         r_err_count <= '0;
         r_consec    <= '0;
         r_lost_run  <= 1'b0;
      end else begin
         r_s1_valid  <= bus.in_valid;
         r_out_valid <= 1'b0;
         r_step_err  <= 1'b0;
         if (r_s1_valid) begin
            r_out_valid <= 1'b1;
            r_bin       <= w_cur;
            r_prev      <= w_cur;
            // Direction and error reporting apply once a reference value exists.
            if (r_state != ACQUIRE) begin
               if (w_up) begin
                  r_dir_up <= 1'b1;
               end
               if (w_down) begin
                  r_dir_up <= 1'b0;
               end
               if (w_illegal) begin
                  r_step_err <= 1'b1;
                  if (r_err_count != '1) begin
                     r_err_count <= r_err_count + 1'b1;
                  end
               end
            end
            case (r_state)
               ACQUIRE: begin
                  r_state  <= TRACK;
                  r_locked <= 1'b1;
                  r_consec <= '0;
               end
               TRACK: begin
                  if (w_illegal) begin
                     if (w_consec_inc == ERR_LIMIT_C) begin
                        r_state    <= LOST;
                        r_locked   <= 1'b0;
                        r_consec   <= '0;
                        r_lost_run <= 1'b0;
                     end else begin
                        r_consec <= w_consec_inc;
                     end
                  end else begin
                     r_consec <= '0;
                  end
               end
               LOST: begin
                  if (w_illegal) begin
                     r_lost_run <= 1'b0;
                  end else if (w_up || w_down) begin
                     if (r_lost_run) begin
                        r_state    <= TRACK;
                        r_locked   <= 1'b1;
                        r_consec   <= '0;
                        r_lost_run <= 1'b0;
                     end else begin
                        r_lost_run <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state  <= ACQUIRE;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.bin_out   = r_bin;
   assign bus.dir_up    = r_dir_up;
   assign bus.step_err  = r_step_err;
   assign bus.locked    = r_locked;
   assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder (WIDTH=3, ERR_LIMIT=4).
module tb_gray_step_decoder;

   localparam int WIDTH = 3;

   typedef struct {
      logic             v;     // sample valid / expected out_valid
      logic [WIDTH-1:0] g;     // Gray input
      logic [WIDTH-1:0] bin;   // expected bin_out
      logic             dir;   // expected dir_up
      logic             err;   // expected step_err
      int               lock;  // expected locked, negative = not checked
   } vec_t;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_bad;
   vec_t q[$];

   gray_step_decoder_if #(.WIDTH(WIDTH)) bus ();

   gray_step_decoder #(
      .WIDTH     (WIDTH),
      .ERR_LIMIT (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   function automatic void add(input logic v, input logic [WIDTH-1:0] g,
                               input logic [WIDTH-1:0] bin, input logic dir,
                               input logic err, input int lock);
      vec_t e;
      e.v = v; e.g = g; e.bin = bin; e.dir = dir; e.err = err; e.lock = lock;
      q.push_back(e);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n     = 1'b0;
      bus.in_valid = 1'b0;
      bus.gray_in  = '0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Drives one queued entry per cycle; outputs of entry i are checked two cycles later.
   task automatic run_vecs(input string name);
      int n;
      n = q.size();
      for (int i = 0; i < n + 2; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            vec_t e;
            e = q[i-2];
            chk($sformatf("%s[%0d] out_valid", name, i-2), 32'(bus.out_valid), 32'(e.v));
            chk($sformatf("%s[%0d] bin_out",   name, i-2), 32'(bus.bin_out),   32'(e.bin));
            chk($sformatf("%s[%0d] dir_up",    name, i-2), 32'(bus.dir_up),    32'(e.dir));
            chk($sformatf("%s[%0d] step_err",  name, i-2), 32'(bus.step_err),  32'(e.err));
            if (e.lock >= 0) begin
               chk($sformatf("%s[%0d] locked", name, i-2), 32'(bus.locked), 32'(e.lock));
            end
         end
         if (i < n) begin
            bus.in_valid = q[i].v;
            bus.gray_in  = q[i].g;
         end else begin
            bus.in_valid = 1'b0;
            bus.gray_in  = '0;
         end
      end
      q.delete();
   endtask

   task automatic chk_reset_values(input string name);
      chk({name, " out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({name, " bin_out"},   32'(bus.bin_out),   32'd0);
      chk({name, " dir_up"},    32'(bus.dir_up),    32'd1);
      chk({name, " step_err"},  32'(bus.step_err),  32'd0);
      chk({name, " locked"},    32'(bus.locked),    32'd0);
      chk({name, " err_count"}, 32'(bus.err_count), 32'd0);
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.gray_in  = '0;
      repeat (2) @(negedge clk);
      chk_reset_values("reset");
      reset_n = 1'b1;

      // Up count 0..7 and the 7 -> 0 wrap.
      do_reset();
      add(1, 3'b000, 3'd0, 1, 0, -1);
      add(1, 3'b001, 3'd1, 1, 0, 1);
      add(1, 3'b011, 3'd2, 1, 0, 1);
      add(1, 3'b010, 3'd3, 1, 0, 1);
      add(1, 3'b110, 3'd4, 1, 0, 1);
      add(1, 3'b111, 3'd5, 1, 0, 1);
      add(1, 3'b101, 3'd6, 1, 0, 1);
      add(1, 3'b100, 3'd7, 1, 0, 1);
      add(1, 3'b000, 3'd0, 1, 0, 1);
      run_vecs("up");
      chk("up err_count", 32'(bus.err_count), 32'd0);

      // Down count with the 0 -> 7 wrap; first sample only acquires.
      do_reset();
      add(1, 3'b000, 3'd0, 1, 0, -1);
      add(1, 3'b100, 3'd7, 0, 0, 1);
      add(1, 3'b101, 3'd6, 0, 0, 1);
      add(1, 3'b111, 3'd5, 0, 0, 1);
      add(1, 3'b110, 3'd4, 0, 0, 1);
      add(1, 3'b010, 3'd3, 0, 0, 1);
      add(1, 3'b011, 3'd2, 0, 0, 1);
      add(1, 3'b001, 3'd1, 0, 0, 1);
      add(1, 3'b000, 3'd0, 0, 0, 1);
      run_vecs("down");
      chk("down err_count", 32'(bus.err_count), 32'd0);

      // Single illegal jump 0 -> 2, then a hold.
      do_reset();
      add(1, 3'b000, 3'd0, 1, 0, -1);
      add(1, 3'b011, 3'd2, 1, 1, 1);
      add(1, 3'b011, 3'd2, 1, 0, 1);
      run_vecs("jump");
      chk("jump err_count", 32'(bus.err_count), 32'd1);

      // Four illegal jumps lose lock; two legal up steps regain it.
      do_reset();
      add(1, 3'b000, 3'd0, 1, 0, -1);
      add(1, 3'b011, 3'd2, 1, 1, 1);
      add(1, 3'b110, 3'd4, 1, 1, 1);
      add(1, 3'b101, 3'd6, 1, 1, 1);
      add(1, 3'b000, 3'd0, 1, 1, 0);
      add(1, 3'b001, 3'd1, 1, 0, 0);
      add(1, 3'b011, 3'd2, 1, 0, 1);
      run_vecs("lose");
      chk("lose err_count", 32'(bus.err_count), 32'd4);

      // Gaps in in_valid: outputs hold, exactly two pulses.
      do_reset();
      add(1, 3'b001, 3'd1, 1, 0, -1);
      add(0, 3'b000, 3'd1, 1, 0, -1);
      add(0, 3'b000, 3'd1, 1, 0, -1);
      add(0, 3'b000, 3'd1, 1, 0, -1);
      add(1, 3'b011, 3'd2, 1, 0, 1);
      add(0, 3'b000, 3'd2, 1, 0, 1);
      run_vecs("gap");
      chk("gap err_count", 32'(bus.err_count), 32'd0);

      // Reset while samples are in flight; the following sample re-acquires.
      do_reset();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.gray_in  = 3'b001;
      @(negedge clk);
      bus.gray_in  = 3'b011;
      @(negedge clk);
      reset_n      = 1'b0;
      bus.in_valid = 1'b1;
      bus.gray_in  = 3'b111;
      @(negedge clk);
      chk_reset_values("midreset");
      reset_n      = 1'b1;
      bus.in_valid = 1'b1;
      bus.gray_in  = 3'b101;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("midreset dropped out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("midreset out_valid", 32'(bus.out_valid), 32'd1);
      chk("midreset bin_out",   32'(bus.bin_out),   32'd6);
      chk("midreset step_err",  32'(bus.step_err),  32'd0);
      chk("midreset dir_up",    32'(bus.dir_up),    32'd1);
      chk("midreset err_count", 32'(bus.err_count), 32'd0);

      // 256 illegal steps: err_count saturates at 255 while step_err keeps pulsing.
      do_reset();
      add(1, 3'b000, 3'd0, 1, 0, -1);
      for (int k = 1; k <= 256; k++) begin
         if (k % 2 == 1) add(1, 3'b011, 3'd2, 1, 1, -1);
         else            add(1, 3'b000, 3'd0, 1, 1, -1);
      end
      run_vecs("sat");
      chk("sat err_count", 32'(bus.err_count), 32'd255);
      chk("sat locked",    32'(bus.locked),    32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gray_step_decoder.md
# gray_step_decoder

Receive-side companion to the team's Gray-code counter. It samples a WIDTH-bit Gray-coded count, converts it to binary and checks each new value against the previous one. A legal step is up or down by exactly 1, including wrap-around. The block reports direction and illegal jumps, and keeps a lock state machine so downstream logic knows when the count stream can be trusted.

## Interface
Parameters:
- WIDTH, default 3: Gray/binary code width (≥2).
- ERR_LIMIT, default 4: number of consecutive illegal steps in TRACK that forces LOST (≥1).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  gray_in carries a new sample this cycle.
- gray_in  input  WIDTH  Gray-coded count.
- out_valid  output  1  one-cycle pulse; bin_out/step flags updated.
- bin_out  output  WIDTH  binary value of the last accepted sample.
- dir_up  output  1  1 = last legal step was +1; 0 = last legal step was −1.
- step_err  output  1  one-cycle pulse with out_valid when the step is illegal.
- locked  output  1  high while the state machine is in TRACK.
- err_count  output  8  total illegal steps, saturates at 255.

## Operation
- Stage 1 registers gray_in and in_valid unconditionally.
- Stage 2 acts when the stage-1 valid is high:
  - Conversion: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - delta = cur − prev, taken modulo 2^WIDTH.
- Step classification:
  - delta = 0: hold. No error; dir_up unchanged.
  - delta = 1: up. dir_up = 1. This includes the wrap 2^WIDTH−1 → 0.
  - delta = all-ones: down. dir_up = 0. This includes the wrap 0 → 2^WIDTH−1.
  - Any other delta: illegal. step_err pulses; err_count += 1, saturating at 255.
- prev is updated to cur on every valid sample, legal or not.
- State machine (state, prev and counters are held when stage-1 valid is low):
  - ACQUIRE (after reset): the first valid sample loads prev and bin_out and pulses out_valid. No step check is made and dir_up is unchanged. Next state is TRACK.
  - TRACK: locked = 1. Each illegal step increments the consecutive-error counter; any legal step or hold clears it. When the counter reaches ERR_LIMIT, go to LOST.
  - LOST: locked = 0. Steps are still classified and reported. Two consecutive legal ±1 steps return to TRACK and clear the error counter. A hold does not count toward the two steps and does not break the run. An illegal step restarts the run.
- step_err is reported in every state except ACQUIRE.

## Timing
- Latency: a sample presented with in_valid in cycle N appears on out_valid/bin_out/dir_up/step_err in cycle N+2.
- Throughput: one sample per cycle. Back-to-back in_valid is fully supported.
- out_valid and step_err are single-cycle pulses. bin_out, dir_up and locked hold their values between pulses.
- Reset (reset_n low at a rising edge):
  - State → ACQUIRE.
  - bin_out = 0, dir_up = 1, out_valid = 0, step_err = 0, locked = 0, err_count = 0.
  - Stage-1 valid is cleared; the consecutive-error counter and LOST run counter are cleared.
- Reset mid-stream discards the sample in flight. The next valid sample re-acquires.
- locked changes in the same cycle as the out_valid pulse that caused the state transition.
- err_count saturation: at 255 it holds 255, and step_err still pulses.

## Structure
- Shared package gray_pkg:
  - state enum {ACQUIRE, TRACK, LOST}.
  - Function gray2bin(WIDTH), also used by the counter's test bench.
  - Constant ERR_CNT_W = 8.
- No sub-module: the conversion is a package function and the block is a single module.

## Test plan
All scenarios use WIDTH=3 and ERR_LIMIT=4.
- Up sequence 000,001,011,010,110,111,101,100,000 with in_valid high every cycle:
  - bin_out = 0,1,…,7,0, each 2 cycles after input.
  - dir_up = 1, no step_err, locked = 1 from the second out_valid onward.
  - The wrap 7 → 0 is legal.
- Same sequence reversed, starting at 000: bin_out = 0,7,6,…,0 with dir_up = 0 and no step_err. The wrap 0 → 7 is legal.
- 000 then 011 (binary 0 → 2): step_err pulses once, err_count = 1, locked stays 1. A repeated 011 gives a hold with no error.
- Four consecutive illegal jumps (bin 0,2,4,6,0):
  - locked drops in the cycle of the fourth step_err; err_count = 4.
  - Then legal steps 1,2: locked returns to 1 on the second legal step.
- in_valid gaps: samples 001, 3 idle cycles, 011. Exactly two out_valid pulses, no error, outputs held during the gap.
- reset_n low for one cycle while samples are in flight: all outputs at reset values, the in-flight sample is dropped, and the next sample 101 gives bin_out = 6 with no step_err (ACQUIRE).
